// File: rtl/im_fold_fetcher.sv
// Item-memory fold fetcher: accepts IM load writes and channel fetch requests,
// then streams the NUM_FOLDS fold words of a channel through a 3-entry FIFO.
module im_fold_fetcher #(
  parameter int FOLD_WIDTH      = 500,
  parameter int SRAM_ADDR_WIDTH = 10,
  parameter int NUM_FOLDS       = 8,
  parameter int NUM_CHANNELS    = 108,
  parameter int CHAN_WIDTH      = 7,
  localparam int IDX_W          = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [CHAN_WIDTH-1:0]      req_chan,
  output logic                       req_err,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
  input  logic [FOLD_WIDTH-1:0]      wr_data,
  output logic                       im_we,
  output logic [SRAM_ADDR_WIDTH-1:0] im_addr,
  output logic [FOLD_WIDTH-1:0]      im_din,
  input  logic [FOLD_WIDTH-1:0]      im_dout,
  output logic                       fold_valid,
  input  logic                       fold_ready,
  output logic [FOLD_WIDTH-1:0]      fold_data,
  output logic [IDX_W-1:0]           fold_idx,
  output logic                       fold_last,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CW1 = CHAN_WIDTH + 1;
  localparam logic [CW1-1:0]   CHAN_LIMIT = CW1'(NUM_CHANNELS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_FOLDS - 1);

  state_t                       state_r;
  state_t                       state_nxt_s;
  logic                         rd_issue_r;
  logic                         rd_wait_r;
  logic [IDX_W-1:0]             issue_cnt_r;
  logic [IDX_W-1:0]             out_idx_r;
  logic [SRAM_ADDR_WIDTH-1:0]   base_r;
  logic                         req_err_r;
  logic                         im_we_r;
  logic [SRAM_ADDR_WIDTH-1:0]   im_addr_r;
  logic [FOLD_WIDTH-1:0]        im_din_r;
  logic [FOLD_WIDTH-1:0]        fifo_mem_r [3];
  logic [1:0]                   fifo_rd_ptr_r;
  logic [1:0]                   fifo_wr_ptr_r;
  logic [1:0]                   fifo_cnt_r;
  logic                         wr_acc_s;
  logic                         req_acc_s;
  logic                         req_ok_s;
  logic                         pop_s;
  logic                         issue_s;
  logic                         last_issue_s;
  logic                         drain_done_s;
  logic [1:0]                   in_flight_s;
  logic [2:0]                   credit_s;
  logic [FOLD_WIDTH-1:0]        head_s;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign wr_ready     = rst_n && (state_r == IDLE);
  assign req_ready    = rst_n && (state_r == IDLE) && !wr_valid;
  assign wr_acc_s     = wr_valid && wr_ready;
  assign req_acc_s    = req_valid && req_ready;
  assign req_ok_s     = req_acc_s && ({1'b0, req_chan} < CHAN_LIMIT);
  assign pop_s        = fold_valid && fold_ready;
  assign in_flight_s  = {1'b0, rd_issue_r} + {1'b0, rd_wait_r};
  // A slot freed by this cycle's pop can be refilled by this cycle's issue.
  assign credit_s     = {1'b0, in_flight_s} + {1'b0, fifo_cnt_r} - {2'b00, pop_s};
  assign issue_s      = (state_r == FETCH) && (credit_s < 3'd3);
  assign last_issue_s = issue_s && (issue_cnt_r == LAST_IDX);
  assign drain_done_s = (in_flight_s == 2'd0) &&
                        ((fifo_cnt_r == 2'd0) || ((fifo_cnt_r == 2'd1) && pop_s));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_ok_s) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        if (last_issue_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // IM port, read pipeline tracking and request bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_issue_r  <= 1'b0;
      rd_wait_r   <= 1'b0;
      issue_cnt_r <= '0;
      base_r      <= '0;
      req_err_r   <= 1'b0;
      im_we_r     <= 1'b1;
      im_addr_r   <= '0;
      im_din_r    <= '0;
    end else begin
      rd_issue_r <= issue_s;
      rd_wait_r  <= rd_issue_r;
      req_err_r  <= req_acc_s && !req_ok_s;
      if (req_ok_s) begin
        base_r      <= SRAM_ADDR_WIDTH'(req_chan) * SRAM_ADDR_WIDTH'(NUM_FOLDS);
        issue_cnt_r <= '0;
      end else if (issue_s) begin
        issue_cnt_r <= issue_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end else begin
        issue_cnt_r <= issue_cnt_r;
      end
      if (wr_acc_s) begin
        im_we_r   <= 1'b0;
        im_addr_r <= wr_addr;
        im_din_r  <= wr_data;
      end else if (issue_s) begin
        im_we_r   <= 1'b1;
        im_addr_r <= base_r + SRAM_ADDR_WIDTH'(issue_cnt_r);
      end else begin
        im_we_r   <= 1'b1;
      end
    end
  end

  // Fold FIFO: capture IM data the cycle after a read address, pop on handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_rd_ptr_r <= 2'd0;
      fifo_wr_ptr_r <= 2'd0;
      fifo_cnt_r    <= 2'd0;
      out_idx_r     <= '0;
      for (int i = 0; i < 3; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rd_wait_r && (fifo_wr_ptr_r == 2'(i))) begin
          fifo_mem_r[i] <= im_dout;
        end else begin
          fifo_mem_r[i] <= fifo_mem_r[i];
        end
      end
      if (rd_wait_r) begin
        fifo_wr_ptr_r <= ptr_inc(fifo_wr_ptr_r);
      end else begin
        fifo_wr_ptr_r <= fifo_wr_ptr_r;
      end
      if (pop_s) begin
        fifo_rd_ptr_r <= ptr_inc(fifo_rd_ptr_r);
      end else begin
        fifo_rd_ptr_r <= fifo_rd_ptr_r;
      end
      fifo_cnt_r <= fifo_cnt_r + {1'b0, rd_wait_r} - {1'b0, pop_s};
      if (req_ok_s) begin
        out_idx_r <= '0;
      end else if (pop_s) begin
        out_idx_r <= out_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end else begin
        out_idx_r <= out_idx_r;
      end
    end
  end

  // FIFO head select
  always_comb begin
    head_s = '0;
    case (fifo_rd_ptr_r)
      2'd0:    head_s = fifo_mem_r[0];
      2'd1:    head_s = fifo_mem_r[1];
      2'd2:    head_s = fifo_mem_r[2];
      default: head_s = fifo_mem_r[0];
    endcase
  end

  assign fold_valid = (fifo_cnt_r != 2'd0);
  assign fold_data  = head_s;
  assign fold_idx   = out_idx_r;
  assign fold_last  = fold_valid && (out_idx_r == LAST_IDX);
  assign busy       = (state_r != IDLE);
  assign req_err    = req_err_r;
  assign im_we      = im_we_r;
  assign im_addr    = im_addr_r;
  assign im_din     = im_din_r;

endmodule

// File: tb/tb_im_fold_fetcher.sv
// Directed self-checking bench for im_fold_fetcher with a behavioural
// single-port IM (one-cycle read latency).
module tb_im_fold_fetcher;
  localparam int FW = 500;
  localparam int AW = 10;
  localparam int NF = 8;
  localparam int CW = 7;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_chan;
  logic          req_err;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [FW-1:0] wr_data;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [FW-1:0] im_din;
  logic [FW-1:0] im_dout;
  logic          fold_valid;
  logic          fold_ready;
  logic [FW-1:0] fold_data;
  logic [IW-1:0] fold_idx;
  logic          fold_last;
  logic          busy;

  logic [FW-1:0] im_mem [1024];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  im_fold_fetcher dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan), .req_err(req_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .im_we(im_we), .im_addr(im_addr), .im_din(im_din), .im_dout(im_dout),
    .fold_valid(fold_valid), .fold_ready(fold_ready), .fold_data(fold_data),
    .fold_idx(fold_idx), .fold_last(fold_last), .busy(busy)
  );

  // IM model: synchronous write when im_we low, registered read every cycle.
  always @(posedge clk) begin
    if (!im_we) im_mem[im_addr] <= im_din;
    im_dout <= im_mem[im_addr];
  end

  function automatic logic [FW-1:0] pat(input int a);
    logic [503:0] t;
    t = {63{8'hA5}};
    return t[499:0] ^ {a[31:0], 436'd0, a[31:0]};
  endfunction

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input int chan);
    req_valid = 1'b1;
    req_chan  = CW'(chan);
    #1;
    check("req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  // mode 0: fold_ready held high; mode 1: fold_ready toggles each cycle
  task automatic drain_fetch(input int mode, input int base);
    int exp_i;
    int cyc;
    logic pv;
    logic pr;
    logic [FW-1:0] pd;
    exp_i = 0;
    cyc = 0;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    while (exp_i < NF && cyc < 80) begin
      fold_ready = (mode == 0) ? 1'b1 : cyc[0];
      if (fold_valid) begin
        check("fold_idx", fold_idx, exp_i);
        check("fold_data", fold_data, pat(base + exp_i));
        check("fold_last", fold_last, exp_i == NF - 1);
        if (pv && !pr) check("stall_hold", fold_data, pd);
        if (fold_ready) exp_i++;
      end
      pv = fold_valid;
      pr = fold_ready;
      pd = fold_data;
      tick();
      cyc++;
    end
    check("fold_count", exp_i, NF);
    check("busy_end", busy, 0);
    check("valid_end", fold_valid, 0);
    fold_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] saved;
    logic found;
    for (int i = 0; i < 1024; i++) im_mem[i] = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_chan = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; fold_ready = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_im_we", im_we, 1);
    check("rst_im_addr", im_addr, 0);
    check("rst_im_din", im_din, 0);
    check("rst_fold_valid", fold_valid, 0);
    check("rst_req_err", req_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // load channel 2 (addresses 16..23)
    for (int i = 0; i < NF; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(16 + i);
      wr_data  = pat(16 + i);
      #1;
      check("wr_ready", wr_ready, 1);
      tick();
      check("wr_im_we", im_we, 0);
      check("wr_im_addr", im_addr, 16 + i);
      check("wr_im_din", im_din, pat(16 + i));
    end
    wr_valid = 1'b0;
    tick();
    check("wr_done_im_we", im_we, 1);
    check("wr_done_addr_hold", im_addr, 23);

    // fetch channel 2 with fold_ready high: exact timing
    fold_ready = 1'b1;
    start_fetch(2);
    check("f0_busy", busy, 1);
    check("f0_valid", fold_valid, 0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k <= 8) check("f_im_addr", im_addr, 16 + k - 1);
      check("f_im_we", im_we, 1);
      check("f_valid", fold_valid, (k >= 3 && k <= 10));
      if (k >= 3 && k <= 10) begin
        check("f_idx", fold_idx, k - 3);
        check("f_data", fold_data, pat(16 + k - 3));
        check("f_last", fold_last, k == 10);
      end
      check("f_busy", busy, k <= 10);
    end

    // backpressure: stall fully, then toggle fold_ready
    fold_ready = 1'b0;
    start_fetch(2);
    repeat (8) tick();
    check("bp_addr_stall", im_addr, 18);
    check("bp_valid", fold_valid, 1);
    check("bp_idx", fold_idx, 0);
    check("bp_data", fold_data, pat(16));
    drain_fetch(1, 16);

    // simultaneous write and request in IDLE: write wins
    wr_valid = 1'b1; wr_addr = AW'(100); wr_data = pat(100);
    req_valid = 1'b1; req_chan = CW'(2);
    #1;
    check("sim_req_ready", req_ready, 0);
    check("sim_wr_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    #1;
    check("sim_im_we", im_we, 0);
    check("sim_im_addr", im_addr, 100);
    check("sim_im_din", im_din, pat(100));
    check("sim_busy", busy, 0);
    check("sim_req_ready2", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("sim_busy2", busy, 1);
    check("sim_im_we2", im_we, 1);
    drain_fetch(0, 16);

    // out-of-range channel
    saved = im_addr;
    req_valid = 1'b1; req_chan = CW'(108);
    #1;
    check("oor_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("oor_req_err", req_err, 1);
    check("oor_busy", busy, 0);
    check("oor_addr", im_addr, saved);
    tick();
    check("oor_req_err_clr", req_err, 0);
    check("oor_addr2", im_addr, saved);
    check("oor_valid", fold_valid, 0);
    check("oor_busy2", busy, 0);

    // reset in the middle of a fetch
    fold_ready = 1'b1;
    start_fetch(2);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (fold_valid && fold_idx == 3'd4) found = 1'b1;
    end
    check("reach_fold4", found, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_ready", wr_ready, 0);
    check("mid_rst_req_ready", req_ready, 0);
    tick();
    check("mid_rst_valid", fold_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_im_we", im_we, 1);
    check("mid_rst_im_addr", im_addr, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", fold_valid, 0);
    start_fetch(2);
    drain_fetch(0, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/im_fold_fetcher.md
IM_FOLD_FETCHER -- requirements
Module: im_fold_fetcher

Interface
REQ-001 Params (name, default, meaning): FOLD_WIDTH, 500, bits per fold word; SRAM_ADDR_WIDTH, 10, IM address width; NUM_FOLDS, 8, folds per channel hypervector; NUM_CHANNELS, 108, channels stored (NUM_FOLDS*NUM_CHANNELS <= 864); CHAN_WIDTH, 7, channel index width.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst_n  in  1  one clock; reset synchronous, active-low.
REQ-004 req_valid / req_ready  in / out  1 / 1  channel fetch request handshake.
REQ-005 req_chan  in  CHAN_WIDTH  channel whose hypervector is fetched.
REQ-006 req_err  out  1  one-cycle pulse: out-of-range request dropped.
REQ-007 wr_valid / wr_ready  in / out  1 / 1  IM load handshake.
REQ-008 wr_addr, wr_data  in  SRAM_ADDR_WIDTH, FOLD_WIDTH  load address/word.
REQ-009 im_we  out  1  IM write enable, active-low (1 = read).
REQ-010 im_addr, im_din  out  SRAM_ADDR_WIDTH, FOLD_WIDTH  IM address/write data, registered.
REQ-011 im_dout  in  FOLD_WIDTH  IM read data, valid the cycle after address presented.
REQ-012 fold_valid / fold_ready  out / in  1 / 1  fold output handshake to spatial encoder.
REQ-013 fold_data, fold_idx, fold_last  out  FOLD_WIDTH, clog2(NUM_FOLDS), 1  fold word, index, final-fold flag.
REQ-014 busy  out  1  high whenever state != IDLE.

Function
REQ-015 States SHALL be IDLE, FETCH, DRAIN.
REQ-016 IDLE: wr_ready=1; req_ready = !wr_valid (write wins simultaneous arrival).
REQ-017 Write accepted at edge E SHALL drive im_we=0, im_addr=wr_addr, im_din=wr_data for exactly the cycle after E; im_we=1 at all other times.
REQ-018 Request accepted with req_chan < NUM_CHANNELS: latch base = req_chan*NUM_FOLDS, issue_cnt=0, go FETCH; wr_ready=0, req_ready=0 outside IDLE.
REQ-019 Request with req_chan >= NUM_CHANNELS: accepted, no IM read, req_err=1 next cycle, stay IDLE.
REQ-020 FETCH: read issued (im_addr <= base+issue_cnt, issue_cnt++) only when in_flight + buf_occupancy < 3; after fold NUM_FOLDS-1 issued go DRAIN.
REQ-021 im_dout for a read SHALL be captured into a 3-entry FIFO exactly one cycle after its address is on im_addr; im_dout ignored all other cycles (IM reads every cycle).
REQ-022 FIFO head drives fold_*; pop on fold_valid && fold_ready; fold_data stable while fold_valid && !fold_ready.
REQ-023 fold_idx SHALL run 0..NUM_FOLDS-1 in address order; fold_last=1 only at NUM_FOLDS-1.
REQ-024 DRAIN -> IDLE when in_flight=0 and FIFO empty after final pop; next request acceptable the following cycle.
REQ-025 Latency: fold 0 fold_valid asserted 3 cycles after request-acceptance edge.
REQ-026 Throughput: fold_ready held high -> NUM_FOLDS folds on consecutive cycles, no bubbles.
REQ-027 Backpressure: FIFO never overflows; no fold dropped or duplicated for any fold_ready pattern.
REQ-028 im_addr SHALL hold last value when no access issued.

Reset
REQ-029 rst_n low at an edge: state=IDLE, FIFO empty, in_flight=0, issue_cnt=0, im_we=1, im_addr=0, im_din=0, fold_valid=0, req_err=0, busy=0.
REQ-030 While rst_n low: req_ready=0, wr_ready=0.
REQ-031 Reset mid-FETCH/DRAIN SHALL discard in-flight and buffered folds; im_dout of the first post-reset cycle never captured.

Verification
REQ-032 Load: write 0xA5-pattern to addr 16..23 -> im_we=0 one cycle each, addresses 16..23 in order, wr_ready=1 throughout.
REQ-033 Fetch chan 2, fold_ready=1 -> im_addr 16..23; fold_valid 3 cycles after accept, 8 consecutive folds, fold_idx 0..7, fold_last on 7th, busy drops next cycle.
REQ-034 Fetch chan 2, fold_ready toggling 1/0 -> same 8 words in order, stable while stalled, issue stalls when occupancy+in_flight=3.
REQ-035 wr_valid and req_valid same cycle in IDLE -> write accepted, req_ready=0; request accepted next cycle.
REQ-036 req_chan=108 -> req_err pulse, no im_addr change, state IDLE.
REQ-037 rst_n low at fold 4 of a fetch -> next cycle fold_valid=0, busy=0, im_we=1; new fetch returns correct folds 0..7.
